// File: rtl/tlul_intg_err_gate.sv
// Blocks TL-UL requests after the first integrity error: drains the device, answers with an error, then self-answers forever.
// Latency: A/D pass through combinationally; local error reply 1 cycle after drain/accept. Backpressure: A stalls at MaxOutstanding, D follows d_ready_i.
module tlul_intg_err_gate #(
  parameter int SrcW           = 8,
  parameter int MaxOutstanding = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            a_valid_i,
  output logic            a_ready_o,
  input  logic [2:0]      a_opcode_i,
  input  logic [1:0]      a_size_i,
  input  logic [SrcW-1:0] a_source_i,
  input  logic            intg_err_i,
  output logic            dn_a_valid_o,
  input  logic            dn_a_ready_i,
  input  logic            dn_d_valid_i,
  output logic            dn_d_ready_o,
  input  logic [2:0]      dn_d_opcode_i,
  input  logic [1:0]      dn_d_size_i,
  input  logic [SrcW-1:0] dn_d_source_i,
  input  logic            dn_d_error_i,
  input  logic [31:0]     dn_d_data_i,
  output logic            d_valid_o,
  input  logic            d_ready_i,
  output logic [2:0]      d_opcode_o,
  output logic [1:0]      d_size_o,
  output logic [SrcW-1:0] d_source_o,
  output logic            d_error_o,
  output logic [31:0]     d_data_o,
  output logic            err_sticky_o
);

  localparam int CntW = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

  localparam logic [2:0] OpGet           = 3'd4;
  localparam logic [2:0] OpAccessAck     = 3'd0;
  localparam logic [2:0] OpAccessAckData = 3'd1;

  typedef struct packed {
    logic [2:0]      opcode;
    logic [1:0]      size;
    logic [SrcW-1:0] source;
  } hdr_t;

  typedef enum logic [1:0] {
    PASS  = 2'd0,
    DRAIN = 2'd1,
    RESP  = 2'd2,
    BLOCK = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  hdr_t            cap_q, cap_d;
  hdr_t            a_hdr;
  logic            err_sticky_q, err_sticky_d;
  logic            fwd_ok;
  logic            dn_a_hs;
  logic            dn_d_hs;

  assign a_hdr = '{opcode: a_opcode_i, size: a_size_i, source: a_source_i};

  always_comb begin
    state_d      = state_q;
    cap_d        = cap_q;
    err_sticky_d = err_sticky_q;
    a_ready_o    = 1'b0;
    dn_a_valid_o = 1'b0;
    dn_d_ready_o = 1'b0;
    d_valid_o    = 1'b0;
    d_opcode_o   = dn_d_opcode_i;
    d_size_o     = dn_d_size_i;
    d_source_o   = dn_d_source_i;
    d_error_o    = dn_d_error_i;
    d_data_o     = dn_d_data_i;
    fwd_ok       = a_valid_i & ~intg_err_i & (cnt_q < MaxCnt);

    unique case (state_q)
      PASS: begin
        dn_a_valid_o = fwd_ok;
        a_ready_o    = fwd_ok & dn_a_ready_i;
        d_valid_o    = dn_d_valid_i;
        dn_d_ready_o = d_ready_i;
        // A flagged request is swallowed here even when the device is full.
        if (a_valid_i && intg_err_i) begin
          a_ready_o    = 1'b1;
          cap_d        = a_hdr;
          err_sticky_d = 1'b1;
          state_d      = DRAIN;
        end
      end
      DRAIN: begin
        d_valid_o    = dn_d_valid_i;
        dn_d_ready_o = d_ready_i;
        if (cnt_q == '0) begin
          state_d = RESP;
        end
      end
      RESP: begin
        d_valid_o  = 1'b1;
        d_error_o  = 1'b1;
        d_size_o   = cap_q.size;
        d_source_o = cap_q.source;
        if (cap_q.opcode == OpGet) begin
          d_opcode_o = OpAccessAckData;
          d_data_o   = '1;
        end else begin
          d_opcode_o = OpAccessAck;
          d_data_o   = '0;
        end
        if (d_ready_i) begin
          state_d = BLOCK;
        end
      end
      BLOCK: begin
        a_ready_o = 1'b1;
        if (a_valid_i) begin
          cap_d   = a_hdr;
          state_d = RESP;
        end
      end
      default: state_d = PASS;
    endcase

    // Handshake outputs are partly combinational from inputs, so hold them low in reset.
    if (rst_i) begin
      a_ready_o    = 1'b0;
      dn_a_valid_o = 1'b0;
      dn_d_ready_o = 1'b0;
      d_valid_o    = 1'b0;
    end
  end

  assign dn_a_hs = dn_a_valid_o & dn_a_ready_i;
  assign dn_d_hs = dn_d_valid_i & dn_d_ready_o;

  always_comb begin
    cnt_d = cnt_q;
    if (dn_a_hs && !dn_d_hs && (cnt_q < MaxCnt)) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (dn_d_hs && !dn_a_hs && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= PASS;
      cnt_q        <= '0;
      cap_q        <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cap_q        <= cap_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign err_sticky_o = err_sticky_q;

  // A device response with nothing outstanding means the device broke protocol.
  assert property (@(posedge clk_i) disable iff (rst_i) !(dn_d_hs && (cnt_q == '0)));
  assert property (@(posedge clk_i) disable iff (rst_i) (cnt_q <= MaxCnt));

endmodule

// File: tb/tb_tlul_intg_err_gate.sv
// Directed bench for tlul_intg_err_gate: a flag-based reference model checked every cycle plus literal spot checks.
module tb_tlul_intg_err_gate;

  localparam int SrcW   = 8;
  localparam int MaxOut = 2;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            a_valid_i, a_ready_o;
  logic [2:0]      a_opcode_i;
  logic [1:0]      a_size_i;
  logic [SrcW-1:0] a_source_i;
  logic            intg_err_i;
  logic            dn_a_valid_o, dn_a_ready_i;
  logic            dn_d_valid_i, dn_d_ready_o;
  logic [2:0]      dn_d_opcode_i;
  logic [1:0]      dn_d_size_i;
  logic [SrcW-1:0] dn_d_source_i;
  logic            dn_d_error_i;
  logic [31:0]     dn_d_data_i;
  logic            d_valid_o, d_ready_i;
  logic [2:0]      d_opcode_o;
  logic [1:0]      d_size_o;
  logic [SrcW-1:0] d_source_o;
  logic            d_error_o;
  logic [31:0]     d_data_o;
  logic            err_sticky_o;

  int checks = 0;
  int errors = 0;

  tlul_intg_err_gate #(.SrcW(SrcW), .MaxOutstanding(MaxOut)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_opcode_i(a_opcode_i),
    .a_size_i(a_size_i), .a_source_i(a_source_i), .intg_err_i(intg_err_i),
    .dn_a_valid_o(dn_a_valid_o), .dn_a_ready_i(dn_a_ready_i),
    .dn_d_valid_i(dn_d_valid_i), .dn_d_ready_o(dn_d_ready_o),
    .dn_d_opcode_i(dn_d_opcode_i), .dn_d_size_i(dn_d_size_i),
    .dn_d_source_i(dn_d_source_i), .dn_d_error_i(dn_d_error_i), .dn_d_data_i(dn_d_data_i),
    .d_valid_o(d_valid_o), .d_ready_i(d_ready_i), .d_opcode_o(d_opcode_o),
    .d_size_o(d_size_o), .d_source_o(d_source_o), .d_error_o(d_error_o),
    .d_data_o(d_data_o), .err_sticky_o(err_sticky_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: fatal = an error has ever been seen, pend = a local error reply is owed,
  // live = that reply is being presented now, outst = device requests still unanswered.
  int          m_outst = 0;
  bit          m_fatal = 0, m_pend = 0, m_live = 0;
  logic [2:0]  m_op  = '0;
  logic [1:0]  m_sz  = '0;
  logic [7:0]  m_src = '0;

  logic        e_a_ready, e_dn_a_valid, e_dn_d_ready, e_d_valid;
  logic [2:0]  e_d_opcode;
  logic [1:0]  e_d_size;
  logic [7:0]  e_d_source;
  logic        e_d_error;
  logic [31:0] e_d_data;

  always_comb begin
    e_a_ready    = 1'b0;
    e_dn_a_valid = 1'b0;
    e_dn_d_ready = 1'b0;
    e_d_valid    = 1'b0;
    e_d_opcode   = dn_d_opcode_i;
    e_d_size     = dn_d_size_i;
    e_d_source   = dn_d_source_i;
    e_d_error    = dn_d_error_i;
    e_d_data     = dn_d_data_i;
    if (!m_fatal) begin
      e_dn_a_valid = a_valid_i && !intg_err_i && (m_outst < MaxOut);
      e_a_ready    = (a_valid_i && intg_err_i) || (e_dn_a_valid && dn_a_ready_i);
      e_d_valid    = dn_d_valid_i;
      e_dn_d_ready = d_ready_i;
    end else if (m_live) begin
      e_d_valid  = 1'b1;
      e_d_error  = 1'b1;
      e_d_size   = m_sz;
      e_d_source = m_src;
      e_d_opcode = (m_op == 3'd4) ? 3'd1 : 3'd0;
      e_d_data   = (m_op == 3'd4) ? 32'hFFFF_FFFF : 32'h0;
    end else if (m_pend) begin
      e_d_valid    = dn_d_valid_i;
      e_dn_d_ready = d_ready_i;
    end else begin
      e_a_ready = 1'b1;
    end
  end

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_outst <= 0; m_fatal <= 0; m_pend <= 0; m_live <= 0;
      m_op <= '0; m_sz <= '0; m_src <= '0;
    end else begin
      m_outst <= m_outst + int'(e_dn_a_valid && dn_a_ready_i) - int'(dn_d_valid_i && e_dn_d_ready);
      if (!m_fatal) begin
        if (a_valid_i && intg_err_i) begin
          m_fatal <= 1; m_pend <= 1; m_live <= 0;
          m_op <= a_opcode_i; m_sz <= a_size_i; m_src <= a_source_i;
        end
      end else if (m_live) begin
        if (d_ready_i) begin m_pend <= 0; m_live <= 0; end
      end else if (m_pend) begin
        if (m_outst == 0) m_live <= 1;
      end else if (a_valid_i) begin
        m_pend <= 1; m_live <= 1;
        m_op <= a_opcode_i; m_sz <= a_size_i; m_src <= a_source_i;
      end
    end
  end

  always @(negedge clk_i) begin
    if (rst_i) begin
      chk("rst_a_ready", a_ready_o, 0);
      chk("rst_dn_a_valid", dn_a_valid_o, 0);
      chk("rst_dn_d_ready", dn_d_ready_o, 0);
      chk("rst_d_valid", d_valid_o, 0);
      chk("rst_err_sticky", err_sticky_o, 0);
    end else begin
      chk("m_a_ready", a_ready_o, e_a_ready);
      chk("m_dn_a_valid", dn_a_valid_o, e_dn_a_valid);
      chk("m_dn_d_ready", dn_d_ready_o, e_dn_d_ready);
      chk("m_d_valid", d_valid_o, e_d_valid);
      chk("m_err_sticky", err_sticky_o, m_fatal);
      if (e_d_valid) begin
        chk("m_d_opcode", d_opcode_o, e_d_opcode);
        chk("m_d_size", d_size_o, e_d_size);
        chk("m_d_source", d_source_o, e_d_source);
        chk("m_d_error", d_error_o, e_d_error);
        chk("m_d_data", d_data_o, e_d_data);
      end
    end
  end

  task automatic idle();
    a_valid_i = 0; a_opcode_i = '0; a_size_i = '0; a_source_i = '0; intg_err_i = 0;
    dn_a_ready_i = 1; dn_d_valid_i = 0; dn_d_opcode_i = '0; dn_d_size_i = '0;
    dn_d_source_i = '0; dn_d_error_i = 0; dn_d_data_i = '0; d_ready_i = 1;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic req(input logic [2:0] op, input logic [1:0] sz, input logic [7:0] src, input logic err);
    a_valid_i = 1; a_opcode_i = op; a_size_i = sz; a_source_i = src; intg_err_i = err;
  endtask

  task automatic rsp(input logic [7:0] src, input logic [31:0] data);
    dn_d_valid_i = 1; dn_d_opcode_i = 3'd1; dn_d_size_i = 2'd2;
    dn_d_source_i = src; dn_d_error_i = 0; dn_d_data_i = data;
  endtask

  initial begin
    // Reset with active inputs: all handshake outputs must stay low.
    idle();
    a_valid_i = 1; dn_d_valid_i = 1;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_lit_a_ready", a_ready_o, 0);
    chk("rst_lit_d_valid", d_valid_o, 0);
    chk("rst_lit_sticky", err_sticky_o, 0);
    idle();
    rst_i = 0;
    step();

    // Clean traffic and backpressure.
    req(3'd4, 2'd2, 8'd1, 0); #1;
    chk("fwd1_dn_a_valid", dn_a_valid_o, 1);
    chk("fwd1_a_ready", a_ready_o, 1);
    step(); a_source_i = 8'd2;
    step(); a_source_i = 8'd3; #1;
    chk("full_a_ready", a_ready_o, 0);
    chk("full_dn_a_valid", dn_a_valid_o, 0);
    step();
    chk("full2_a_ready", a_ready_o, 0);
    rsp(8'd1, 32'hA5A5_0001); #1;
    chk("pt1_d_data", d_data_o, 32'hA5A5_0001);
    chk("pt1_d_source", d_source_o, 1);
    chk("pt1_a_ready", a_ready_o, 0);
    step();
    rsp(8'd2, 32'hA5A5_0002); #1;
    chk("simul_a_ready", a_ready_o, 1);
    chk("simul_dn_d_ready", dn_d_ready_o, 1);
    step(); a_valid_i = 0; #1;
    chk("simul_cnt", dut.cnt_q, 1);
    rsp(8'd3, 32'hA5A5_0003);
    step(); dn_d_valid_i = 0; #1;
    chk("clean_cnt", dut.cnt_q, 0);
    chk("clean_sticky", err_sticky_o, 0);

    // Error with nothing outstanding.
    req(3'd4, 2'd2, 8'd5, 1); #1;
    chk("err0_a_ready", a_ready_o, 1);
    chk("err0_dn_a_valid", dn_a_valid_o, 0);
    step(); idle(); #1;
    chk("err0_sticky", err_sticky_o, 1);
    chk("err0_drain_d_valid", d_valid_o, 0);
    step();
    chk("err0_d_valid", d_valid_o, 1);
    chk("err0_d_opcode", d_opcode_o, 1);
    chk("err0_d_error", d_error_o, 1);
    chk("err0_d_data", d_data_o, 32'hFFFF_FFFF);
    chk("err0_d_source", d_source_o, 5);
    step();
    chk("err0_done_d_valid", d_valid_o, 0);

    // Error with two outstanding.
    rst_i = 1; step(); rst_i = 0; #1;
    chk("r2_sticky", err_sticky_o, 0);
    req(3'd0, 2'd2, 8'd10, 0);
    step(); a_source_i = 8'd11;
    step(); req(3'd0, 2'd2, 8'd7, 1); #1;
    chk("err2_a_ready", a_ready_o, 1);
    chk("err2_dn_a_valid", dn_a_valid_o, 0);
    step(); req(3'd0, 2'd2, 8'd99, 0); #1;
    chk("drain_a_ready", a_ready_o, 0);
    chk("drain_dn_a_valid", dn_a_valid_o, 0);
    rsp(8'd10, 32'h0000_0010); #1;
    chk("drain_pt_source", d_source_o, 10);
    step(); rsp(8'd11, 32'h0000_0011);
    step(); idle(); #1;
    chk("drain_last_d_valid", d_valid_o, 0);
    d_ready_i = 0;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("hold_d_valid", d_valid_o, 1);
      chk("hold_d_opcode", d_opcode_o, 0);
      chk("hold_d_source", d_source_o, 7);
      chk("hold_d_data", d_data_o, 0);
      chk("hold_d_error", d_error_o, 1);
      step();
    end
    d_ready_i = 1; #1;
    chk("hold_end_d_valid", d_valid_o, 1);
    step();
    chk("block_d_valid", d_valid_o, 0);

    // BLOCK: clean and flagged requests are both answered locally.
    req(3'd1, 2'd1, 8'd9, 0); #1;
    chk("blk_a_ready", a_ready_o, 1);
    chk("blk_dn_a_valid", dn_a_valid_o, 0);
    step(); idle(); #1;
    chk("blk_d_valid", d_valid_o, 1);
    chk("blk_d_source", d_source_o, 9);
    chk("blk_d_opcode", d_opcode_o, 0);
    chk("blk_d_size", d_size_o, 1);
    step();
    req(3'd4, 2'd0, 8'd12, 1); #1;
    chk("blk2_a_ready", a_ready_o, 1);
    step(); idle(); #1;
    chk("blk2_d_opcode", d_opcode_o, 1);
    chk("blk2_d_data", d_data_o, 32'hFFFF_FFFF);
    chk("blk2_d_source", d_source_o, 12);
    step();

    // Reset in DRAIN drops the pending error reply.
    rst_i = 1; step(); rst_i = 0;
    req(3'd4, 2'd2, 8'd20, 0);
    step(); req(3'd4, 2'd2, 8'd21, 1);
    step(); idle(); #1;
    chk("rd_sticky", err_sticky_o, 1);
    rst_i = 1; #1;
    chk("rd_async_sticky", err_sticky_o, 0);
    chk("rd_async_d_valid", d_valid_o, 0);
    step(); rst_i = 0;
    step(); step();
    chk("rd_no_resp", d_valid_o, 0);
    chk("rd_sticky_clr", err_sticky_o, 0);
    req(3'd4, 2'd2, 8'd30, 0); #1;
    chk("rd_fwd_dn_a_valid", dn_a_valid_o, 1);
    chk("rd_fwd_a_ready", a_ready_o, 1);
    step(); idle();
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
